// File: rtl/md_pkg.sv
// Shared definitions for the position-read path: read sequencer state
// encoding and default sizing constants.
package md_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_NUM,
    STREAM,
    NEXT_REF,
    FINISH
  } read_state_t;

  localparam int DEFAULT_PARTICLE_ID_WIDTH = 7;
  localparam int DEFAULT_NUM_FILTER        = 7;
  localparam int DEFAULT_DONE_LATENCY      = 2;

  // Width needed to hold a guard count of 0..latency (never narrower than 1 bit).
  function automatic int guard_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/pos_read_controller.sv
// Read sequencer feeding pos_data_preprocessor. For each home-cell reference
// particle it reads the neighbour particle-count word (address 0) and then
// streams neighbour addresses two phases per address until every filter lane
// reports reading_done. Reads freeze while any filter lane is almost full.
//
// Optional build macro POS_READ_PERF_CNT_EN adds stall_cycles/pass_cycles
// performance counters; without it those ports do not exist.
module pos_read_controller
  import md_pkg::*;
#(
  parameter int PARTICLE_ID_WIDTH = DEFAULT_PARTICLE_ID_WIDTH,
  parameter int NUM_FILTER        = DEFAULT_NUM_FILTER,
  parameter int DONE_LATENCY      = DEFAULT_DONE_LATENCY
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PARTICLE_ID_WIDTH-1:0] home_particle_count,
  input  logic [NUM_FILTER-1:0]        filter_almost_full,
  input  logic [NUM_FILTER-1:0]        reading_done,
  output logic                         phase,
  output logic                         reading_particle_num,
  output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  output logic                         pause_reading,
  output logic                         busy,
  output logic                         done
`ifdef POS_READ_PERF_CNT_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  pass_cycles
`endif
);

  localparam int GW = guard_width(DONE_LATENCY);
  localparam logic [GW-1:0] GUARD_MAX = GW'(DONE_LATENCY);
  localparam logic [PARTICLE_ID_WIDTH-1:0] PID_MAX = '1;
  localparam logic [PARTICLE_ID_WIDTH-1:0] PID_ONE = PARTICLE_ID_WIDTH'(1);

  read_state_t                  state_reg;
  logic                         phase_reg;
  logic                         rpn_reg;
  logic [PARTICLE_ID_WIDTH-1:0] pid_reg;
  logic [PARTICLE_ID_WIDTH-1:0] ref_reg;
  logic [PARTICLE_ID_WIDTH-1:0] hcnt_reg;
  logic [GW-1:0]                guard_reg;
  logic                         busy_reg;
  logic                         done_reg;

  logic all_done;
  logic guard_expired;

  assign all_done      = &reading_done;
  assign guard_expired = (guard_reg == GUARD_MAX);
  // Back-pressure is only meaningful while a pass is running.
  assign pause_reading = busy_reg & (|filter_almost_full);

  assign phase                = phase_reg;
  assign reading_particle_num = rpn_reg;
  assign particle_id          = pid_reg;
  assign ref_id               = ref_reg;
  assign busy                 = busy_reg;
  assign done                 = done_reg;

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      phase_reg <= 1'b0;
      rpn_reg   <= 1'b0;
      pid_reg   <= '0;
      ref_reg   <= '0;
      hcnt_reg  <= '0;
      guard_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            hcnt_reg <= home_particle_count;
            busy_reg <= 1'b1;
            if (home_particle_count == '0) begin
              // Empty home cell: nothing to read, report completion directly.
              state_reg <= FINISH;
              done_reg  <= 1'b1;
            end else begin
              ref_reg   <= PID_ONE;
              pid_reg   <= '0;
              phase_reg <= 1'b0;
              rpn_reg   <= 1'b1;
              state_reg <= READ_NUM;
            end
          end
        end

        READ_NUM: begin
          if (!pause_reading) begin
            if (!phase_reg) begin
              phase_reg <= 1'b1;
            end else begin
              phase_reg <= 1'b0;
              pid_reg   <= PID_ONE;
              guard_reg <= '0;
              rpn_reg   <= 1'b0;
              state_reg <= STREAM;
            end
          end
        end

        STREAM: begin
          // The guard keeps counting through pauses so stale done flags age out.
          if (!guard_expired) begin
            guard_reg <= guard_reg + GW'(1);
          end
          if (guard_expired && all_done) begin
            // Completion takes priority over a simultaneous pause.
            phase_reg <= 1'b0;
            state_reg <= NEXT_REF;
          end else if (!pause_reading) begin
            if (!phase_reg) begin
              phase_reg <= 1'b1;
            end else begin
              phase_reg <= 1'b0;
              // Over-reads past the cell end are dropped downstream; just saturate.
              if (pid_reg != PID_MAX) begin
                pid_reg <= pid_reg + PID_ONE;
              end
            end
          end
        end

        NEXT_REF: begin
          if (ref_reg == hcnt_reg) begin
            state_reg <= FINISH;
            done_reg  <= 1'b1;
          end else begin
            ref_reg   <= ref_reg + PID_ONE;
            pid_reg   <= '0;
            rpn_reg   <= 1'b1;
            state_reg <= READ_NUM;
          end
        end

        FINISH: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          rpn_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef POS_READ_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] pass_cnt_reg;

  // Saturating pass/stall cycle counters, cleared when a pass is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      pass_cnt_reg  <= '0;
    end else if ((state_reg == IDLE) && start) begin
      stall_cnt_reg <= '0;
      pass_cnt_reg  <= '0;
    end else begin
      if (busy_reg && (pass_cnt_reg != 32'hFFFF_FFFF)) begin
        pass_cnt_reg <= pass_cnt_reg + 32'd1;
      end
      if (pause_reading && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign pass_cycles  = pass_cnt_reg;
`endif

endmodule

// File: tb/tb_pos_read_controller.sv
// Scoreboard bench for pos_read_controller. A generator expands each pass
// (home count, random back-pressure, random completion timing) into a
// per-cycle schedule of inputs and expected outputs; the driver plays inputs
// and pushes expectations, the monitor pops and compares every cycle.
module tb_pos_read_controller;

  localparam int W  = 7;
  localparam int NF = 7;
  localparam int DL = 2;
  localparam logic [W-1:0] PID_TOP = 7'h7f;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  home_particle_count;
  logic [NF-1:0] filter_almost_full;
  logic [NF-1:0] reading_done;
  logic          phase;
  logic          reading_particle_num;
  logic [W-1:0]  particle_id;
  logic [W-1:0]  ref_id;
  logic          pause_reading;
  logic          busy;
  logic          done;
`ifdef POS_READ_PERF_CNT_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   pass_cycles;
`endif

  pos_read_controller #(
    .PARTICLE_ID_WIDTH(W),
    .NUM_FILTER(NF),
    .DONE_LATENCY(DL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .home_particle_count(home_particle_count),
    .filter_almost_full(filter_almost_full),
    .reading_done(reading_done),
    .phase(phase),
    .reading_particle_num(reading_particle_num),
    .particle_id(particle_id),
    .ref_id(ref_id),
    .pause_reading(pause_reading),
    .busy(busy),
    .done(done)
`ifdef POS_READ_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .pass_cycles(pass_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          start;
    bit [W-1:0]  hcnt;
    bit [NF-1:0] fa;
    bit [NF-1:0] rd;
    bit          busy;
    bit          done;
    bit          phase;
    bit          rpn;
    bit          pause;
    bit [W-1:0]  pid;
    bit [W-1:0]  rf;
  } cyc_t;

  cyc_t sched_q[$];
  cyc_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cycle_no = 0;
  int passes_seen = 0;

  // Values the outputs hold while idle between passes.
  bit         last_phase = 1'b0;
  bit [W-1:0] last_pid   = '0;
  bit [W-1:0] last_ref   = '0;

  function automatic bit [NF-1:0] rand_fa();
    if ($urandom_range(0, 4) != 0) return '0;
    return NF'($urandom_range(1, (1 << NF) - 1));
  endfunction

  function automatic bit [NF-1:0] rd_not_all();
    bit [NF-1:0] v;
    v = '1;
    v[$urandom_range(0, NF - 1)] = 1'b0;
    return v;
  endfunction

  task automatic push(input bit rst_n, input bit st, input bit [W-1:0] hc,
                      input bit [NF-1:0] fa, input bit [NF-1:0] rd,
                      input bit bsy, input bit dn, input bit ph,
                      input bit [W-1:0] pid, input bit [W-1:0] rf, input bit rpn);
    cyc_t c;
    c.rst_n = rst_n; c.start = st; c.hcnt = hc; c.fa = fa; c.rd = rd;
    c.busy = bsy; c.done = dn; c.phase = ph; c.pid = pid; c.rf = rf; c.rpn = rpn;
    c.pause = bsy && (fa != '0);
    sched_q.push_back(c);
  endtask

  // A busy-cycle record: start is randomly poked to confirm it is ignored.
  task automatic push_busy(input bit [NF-1:0] fa, input bit [NF-1:0] rd, input bit dn,
                           input bit ph, input bit [W-1:0] pid, input bit [W-1:0] rf,
                           input bit rpn);
    push(1'b1, 1'($urandom_range(0, 1)), W'($urandom_range(0, 127)), fa, rd,
         1'b1, dn, ph, pid, rf, rpn);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++)
      push(1'b1, 1'b0, W'($urandom), rand_fa(), NF'($urandom), 1'b0, 1'b0,
           last_phase, last_pid, last_ref, 1'b0);
  endtask

  // Expand one pass into cycles. abort_ref: reset pulse in that reference's
  // STREAM (0 = none). sat_ref: that reference streams long enough to saturate.
  task automatic gen_pass(input int hcnt, input int abort_ref, input int sat_ref);
    bit [W-1:0]  pid;
    bit          ph;
    bit [NF-1:0] fa;
    bit [NF-1:0] rd;
    int          done_k;
    push(1'b1, 1'b1, W'(hcnt), rand_fa(), NF'($urandom), 1'b0, 1'b0,
         last_phase, last_pid, last_ref, 1'b0);
    if (hcnt == 0) begin
      push_busy(rand_fa(), NF'($urandom), 1'b1, last_phase, last_pid, last_ref, 1'b0);
      push_idle(1);
      return;
    end
    pid = '0;
    for (int r = 1; r <= hcnt; r++) begin
      // Count word: address 0 read in phase 0 then phase 1, repeated while stalled.
      for (int p = 0; p < 2; p++) begin
        do begin
          fa = rand_fa();
          push_busy(fa, NF'($urandom), 1'b0, 1'(p), '0, W'(r), 1'b1);
        end while (fa != '0);
      end
      pid = 7'd1;
      ph  = 1'b0;
      done_k = (r == sat_ref) ? 400 : DL + $urandom_range(0, 10);
      for (int k = 0; ; k++) begin
        fa = rand_fa();
        if (r == abort_ref && k == 1) begin
          push(1'b0, 1'b0, '0, fa, NF'($urandom), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
          last_phase = 1'b0; last_pid = '0; last_ref = '0;
          push_idle(2);
          return;
        end
        if (k == done_k)      rd = '1;
        else if (k < DL)      rd = $urandom_range(0, 1) ? '1 : NF'($urandom);
        else                  rd = rd_not_all();
        push_busy(fa, rd, 1'b0, ph, pid, W'(r), 1'b0);
        if (k == done_k) break;
        if (fa == '0) begin
          if (ph) begin
            if (pid != PID_TOP) pid = pid + 1'b1;
          end
          ph = ~ph;
        end
      end
      // Reference switch cycle.
      push_busy(rand_fa(), NF'($urandom), 1'b0, 1'b0, pid, W'(r), 1'b0);
    end
    push_busy(rand_fa(), NF'($urandom), 1'b1, 1'b0, pid, W'(hcnt), 1'b0);
    last_phase = 1'b0; last_pid = pid; last_ref = W'(hcnt);
    push_idle(1);
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    cyc_t e;
    logic [2*W+4:0] got, want;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got  = {busy, done, phase, reading_particle_num, pause_reading, particle_id, ref_id};
      want = {e.busy, e.done, e.phase, e.rpn, e.pause, e.pid, e.rf};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL cycle%0d outputs{busy,done,ph,rpn,pause,pid,ref} got %0b %0b %0b %0b %0b %0d %0d expected %0b %0b %0b %0b %0b %0d %0d",
                 cycle_no, busy, done, phase, reading_particle_num, pause_reading,
                 particle_id, ref_id, e.busy, e.done, e.phase, e.rpn, e.pause, e.pid, e.rf);
      end
      if (done === 1'b1) begin
        passes_seen++;
        $display("[TB] pass %0d done at cycle %0d ref_id=%0d particle_id=%0d",
                 passes_seen, cycle_no, ref_id, particle_id);
      end
    end
  end

  initial begin
    cyc_t c;
    rst = 1'b0;
    start = 1'b0;
    home_particle_count = '0;
    filter_almost_full = '0;
    reading_done = '0;

    // Reset state, then a short idle window.
    for (int i = 0; i < 3; i++)
      push(1'b0, 1'b0, '0, rand_fa(), '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    push_idle(2);
    gen_pass(2, 0, 0);
    push_idle(1);
    gen_pass(0, 0, 0);
    gen_pass(3, 0, 0);
    gen_pass(1, 0, 1);
    gen_pass(5, 3, 0);
    gen_pass(2, 0, 0);
    for (int i = 0; i < 20; i++) begin
      push_idle($urandom_range(0, 2));
      gen_pass($urandom_range(0, 5), 0, 0);
    end

    while (sched_q.size() > 0) begin
      c = sched_q.pop_front();
      @(posedge clk);
      #1;
      cycle_no++;
      rst = c.rst_n;
      start = c.start;
      home_particle_count = c.hcnt;
      filter_almost_full = c.fa;
      reading_done = c.rd;
      exp_q.push_back(c);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    filter_almost_full = '0;
    reading_done = '0;
    repeat (2) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cycle_no);
    $fatal(1, "watchdog");
  end

endmodule
